// File: rtl/mem_axi_bridge_if.sv
// rtl/mem_axi_bridge_if.sv - AXI4-Lite channel bundle for mem_axi_bridge
//
// Purpose: groups the five AXI4-Lite channels (AW, W, B, AR, R) into one
// interface so the bridge and its slave connect through a single port.
// Modports:
//   master - bridge side: drives addresses, data, strobes, prot, valids
//            and readys for B/R; samples readys, responses, read data
//   slave  - interconnect/memory side, the mirror image of master
// Parameter: ADDR_WIDTH - width of awaddr/araddr (default 32)

interface mem_axi_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mem_axi_bridge.sv
// rtl/mem_axi_bridge.sv - MMU memory request to AXI4-Lite master bridge
//
// Purpose: takes one physical memory request at a time from the MMU and
// runs it as a single AXI4-Lite read or write, then returns a one-cycle
// completion pulse with the read data (zero for writes).
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset
//   request_enable   - one-cycle request strobe (sampled only in IDLE)
//   req_mode         - 0 read, 1 write
//   req_addr/req_wdata/req_wstrb - request address, write data, strobes
//   response_enable  - one-cycle completion pulse
//   resp_data        - read data, 0 after a write; held until next response
//   resp_error       - only with MEM_AXI_BRIDGE_RESP_ERR_EN: SLVERR/DECERR seen
//   axi              - AXI4-Lite master channels (mem_axi_bridge_if.master)
// Optional feature macro: MEM_AXI_BRIDGE_RESP_ERR_EN

module mem_axi_bridge #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  request_enable,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  response_enable,
  output logic [31:0]           resp_data,
`ifdef MEM_AXI_BRIDGE_RESP_ERR_EN
  output logic                  resp_error,
`endif
  mem_axi_bridge_if.master      axi
);

  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESPOND = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           resp_data_q;
  logic                  aw_done_q, w_done_q;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic rd_err;

  assign ar_hs = axi.arvalid & axi.arready;
  assign r_hs  = axi.rvalid  & axi.rready;
  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid  & axi.wready;
  assign b_hs  = axi.bvalid  & axi.bready;

`ifdef MEM_AXI_BRIDGE_RESP_ERR_EN
  // Bit 1 of an AXI response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  logic wr_err;
  assign rd_err = axi.rresp[1];
  assign wr_err = axi.bresp[1];
`else
  logic unused_resp;
  assign rd_err      = 1'b0;
  assign unused_resp = ^{axi.rresp, axi.bresp};
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (request_enable) begin
          state_d = (req_mode == MEMREQ_WRITE) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (r_hs)  state_d = RESPOND;
      WR_REQ: begin
        // Either channel may already be done, or both may finish this cycle.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WR_RESP;
      end
      WR_RESP: if (b_hs) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, write-channel completion flags and response data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request_enable) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        RD_DATA: begin
          if (r_hs) resp_data_q <= rd_err ? 32'h0 : axi.rdata;
        end
        WR_RESP: begin
          if (b_hs) resp_data_q <= 32'h0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_AXI_BRIDGE_RESP_ERR_EN
  // Error flag is raised together with the response pulse and dropped with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_error <= 1'b0;
    end else if (state_q == RD_DATA && r_hs) begin
      resp_error <= rd_err;
    end else if (state_q == WR_RESP && b_hs) begin
      resp_error <= wr_err;
    end else if (state_q == RESPOND) begin
      resp_error <= 1'b0;
    end
  end
`endif

  // Output decode: valids/readys follow the state directly, so each one is
  // held from state entry until its own handshake and never dropped early.
  always_comb begin
    response_enable = (state_q == RESPOND);
    resp_data       = resp_data_q;
    axi.araddr      = addr_q;
    axi.arprot      = 3'b000;
    axi.arvalid     = (state_q == RD_ADDR);
    axi.rready      = (state_q == RD_DATA);
    axi.awaddr      = addr_q;
    axi.awprot      = 3'b000;
    axi.awvalid     = (state_q == WR_REQ) && !aw_done_q;
    axi.wdata       = wdata_q;
    axi.wstrb       = wstrb_q;
    axi.wvalid      = (state_q == WR_REQ) && !w_done_q;
    axi.bready      = (state_q == WR_RESP);
  end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// tb/tb_mem_axi_bridge.sv - scoreboard testbench for mem_axi_bridge

module tb_mem_axi_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
`ifdef MEM_AXI_BRIDGE_RESP_ERR_EN
  logic        resp_error;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  mem_axi_bridge_if #(.ADDR_WIDTH(32)) axi ();

  mem_axi_bridge #(.ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .request_enable  (request_enable),
    .req_mode        (req_mode),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wstrb       (req_wstrb),
    .response_enable (response_enable),
    .resp_data       (resp_data),
`ifdef MEM_AXI_BRIDGE_RESP_ERR_EN
    .resp_error      (resp_error),
`endif
    .axi             (axi)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic slave_idle();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
  endtask

  // One transaction: pushes the expected response, plays a slave with the
  // given per-channel delays, checks channel rules each cycle and compares
  // the response against the scoreboard. lat = cycles from request to pulse.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] rdata, input logic [1:0] resp,
                         input int aw_dly, input int w_dly, input int ar_dly, input int r_dly,
                         input int b_dly, input int spur, input int tail, output int lat);
    int t = 0, aw_w = 0, w_w = 0, ar_w = 0, r_w = 0, b_w = 0, pulses = 0;
    bit aw_set = 0, w_set = 0, ar_set = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, done = 0;
    exp_t e, got;
    e.data = wr ? 32'h0 : rdata;
    e.err  = 1'b0;
`ifdef MEM_AXI_BRIDGE_RESP_ERR_EN
    e.err = resp[1];
    if (!wr && resp[1]) e.data = 32'h0;
`endif
    exp_q.push_back(e);
    lat = -1;
    @(negedge clk);
    checks++;
    if (response_enable !== 1'b0) begin
      errors++; $display("FAIL pre_idle_resp: got %0b expected 0", response_enable);
    end
    request_enable = 1'b1; req_mode = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
      request_enable = (t == spur);
      if (t == spur) begin
        req_mode = ~wr; req_addr = addr ^ 32'hFFFF_0000; req_wdata = ~wdata;
      end
      if (aw_set) begin aw_hs = 1; aw_set = 0; end
      if (w_set)  begin w_hs  = 1; w_set  = 0; end
      if (ar_set) begin ar_hs = 1; ar_set = 0; end
      // AR channel
      if (ar_w > 0 && !ar_hs && !axi.arvalid) begin
        errors++; $display("FAIL ar_drop: arvalid 0 before handshake at t=%0d", t);
      end
      if (axi.arvalid) begin
        checks++;
        if (axi.araddr !== addr || axi.arprot !== 3'b000 || ar_hs || wr) begin
          errors++; $display("FAIL ar_chan: got araddr %0h prot %0b expected %0h prot 0", axi.araddr, axi.arprot, addr);
        end
        ar_w++; axi.arready = (ar_w > ar_dly); ar_set = axi.arready;
      end else axi.arready = 1'b0;
      // AW channel
      if (aw_w > 0 && !aw_hs && !axi.awvalid) begin
        errors++; $display("FAIL aw_drop: awvalid 0 before handshake at t=%0d", t);
      end
      if (axi.awvalid) begin
        checks++;
        if (axi.awaddr !== addr || axi.awprot !== 3'b000 || aw_hs || !wr) begin
          errors++; $display("FAIL aw_chan: got awaddr %0h prot %0b expected %0h prot 0", axi.awaddr, axi.awprot, addr);
        end
        aw_w++; axi.awready = (aw_w > aw_dly); aw_set = axi.awready;
      end else axi.awready = 1'b0;
      // W channel
      if (w_w > 0 && !w_hs && !axi.wvalid) begin
        errors++; $display("FAIL w_drop: wvalid 0 before handshake at t=%0d", t);
      end
      if (axi.wvalid) begin
        checks++;
        if (axi.wdata !== wdata || axi.wstrb !== wstrb || w_hs || !wr) begin
          errors++; $display("FAIL w_chan: got %0h/%0h expected %0h/%0h", axi.wdata, axi.wstrb, wdata, wstrb);
        end
        w_w++; axi.wready = (w_w > w_dly); w_set = axi.wready;
      end else axi.wready = 1'b0;
      // R channel
      if (axi.rready) begin
        r_w++; axi.rvalid = (r_w > r_dly);
        axi.rdata = axi.rvalid ? rdata : 32'h0BAD_0BAD; axi.rresp = resp;
      end else axi.rvalid = 1'b0;
      // B channel: bready only once both AW and W have handshaken
      if (axi.bready) begin
        checks++;
        if (!(aw_hs && w_hs)) begin
          errors++; $display("FAIL bready_early: got aw_hs %0b w_hs %0b expected 1 1", aw_hs, w_hs);
        end
        b_w++; axi.bvalid = (b_w > b_dly); axi.bresp = resp;
      end else axi.bvalid = 1'b0;
      // Response
      if (response_enable) begin
        pulses++;
        lat = t;
        if (pulses == 1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL sb_empty: response with no expected entry");
          end else begin
            got = exp_q.pop_front();
            if (resp_data !== got.data) begin
              errors++; $display("FAIL resp_data: got %0h expected %0h", resp_data, got.data);
            end
`ifdef MEM_AXI_BRIDGE_RESP_ERR_EN
            checks++;
            if (resp_error !== got.err) begin
              errors++; $display("FAIL resp_error: got %0b expected %0b", resp_error, got.err);
            end
`endif
          end
        end
      end
`ifdef MEM_AXI_BRIDGE_RESP_ERR_EN
      else if (resp_error !== 1'b0) begin
        errors++; $display("FAIL resp_error_idle: got %0b expected 0 at t=%0d", resp_error, t);
      end
`endif
      if (lat >= 0 && t >= lat + tail) done = 1;
    end
    slave_idle();
    request_enable = 1'b0;
    checks++;
    if (pulses !== 1 || !done) begin
      errors++; $display("FAIL pulse_count: got %0d pulses (done=%0b) expected 1", pulses, done);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; request_enable = 1'b0; req_mode = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    slave_idle();
    repeat (3) @(negedge clk);
    checks++;
    if ({response_enable, resp_data, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
         axi.araddr, axi.awaddr, axi.wdata, axi.wstrb} !== '0) begin
      errors++; $display("FAIL reset_outputs: got resp %0b data %0h arv %0b awv %0b wv %0b expected all 0",
                         response_enable, resp_data, axi.arvalid, axi.awvalid, axi.wvalid);
    end
    rstn = 1'b1;
  endtask

  task automatic test_read_zero_wait();
    int lat;
    run_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, -1, 3, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_write_aw_first();
    int lat;
    run_txn(1'b1, 32'h1000_0004, 32'h1234_5678, 4'b0011, 32'h0, 2'b00, 0, 2, 0, 0, 1, -1, 3, lat);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL write_aw_first_latency: got %0d expected 6", lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_txn(1'b1, 32'h2000_0100, 32'hCAFE_F00D, 4'b1111, 32'h0, 2'b00, 0, 0, 0, 0, 0, -1, 0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d expected 3", lat); end
    run_txn(1'b0, 32'h2000_0200, 32'h0, 4'h0, 32'h5A5A_A5A5, 2'b00, 0, 0, 0, 0, 0, -1, 3, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL b2b_read_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_slow_read_spurious();
    int lat;
    run_txn(1'b0, 32'h0000_0ABC, 32'h0, 4'h0, 32'h0F0F_1234, 2'b00, 0, 0, 5, 7, 0, 3, 4, lat);
    checks++;
    if (lat !== 15) begin errors++; $display("FAIL slow_read_latency: got %0d expected 15", lat); end
    run_txn(1'b1, 32'h0000_0040, 32'h7777_8888, 4'b1000, 32'h0, 2'b00, 3, 1, 0, 0, 2, 2, 3, lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL slow_write_latency: got %0d expected 8", lat); end
  endtask

  task automatic test_reset_mid_read();
    int lat;
    @(negedge clk);
    request_enable = 1'b1; req_mode = 1'b0; req_addr = 32'h3000_0000;
    @(negedge clk);
    request_enable = 1'b0;
    axi.arready = axi.arvalid;
    @(negedge clk);
    axi.arready = 1'b0;
    checks++;
    if (axi.rready !== 1'b1) begin errors++; $display("FAIL mid_rd_data: got rready %0b expected 1", axi.rready); end
    axi.rvalid = 1'b1; axi.rdata = 32'h1111_2222;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({response_enable, resp_data, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, axi.araddr} !== '0) begin
      errors++; $display("FAIL async_reset: got resp %0b data %0h rready %0b araddr %0h expected all 0",
                         response_enable, resp_data, axi.rready, axi.araddr);
    end
    @(negedge clk);
    slave_idle();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (response_enable !== 1'b0 || axi.rready !== 1'b0) begin
        errors++; $display("FAIL post_reset_quiet: got resp %0b rready %0b expected 0 0", response_enable, axi.rready);
      end
    end
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'h0, 32'h4444_5555, 2'b00, 0, 0, 1, 0, 0, -1, 3, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL post_reset_read_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_resp_codes();
    int lat;
    run_txn(1'b0, 32'h4000_0000, 32'h0, 4'h0, 32'hBAAD_F00D, 2'b10, 0, 0, 0, 1, 0, -1, 3, lat);
    run_txn(1'b1, 32'h4000_0008, 32'h0102_0304, 4'b0101, 32'h0, 2'b00, 1, 0, 0, 0, 0, -1, 3, lat);
    run_txn(1'b1, 32'h4000_000C, 32'h0506_0708, 4'b1010, 32'h0, 2'b11, 0, 0, 0, 0, 0, -1, 3, lat);
    run_txn(1'b0, 32'h4000_0010, 32'h0, 4'h0, 32'h9999_0000, 2'b01, 0, 0, 0, 0, 0, -1, 3, lat);
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_aw_first();
    test_back_to_back();
    test_slow_read_spurious();
    test_reset_mid_read();
    test_resp_codes();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_axi_bridge.md
Name: mem_axi_bridge

Overview:
- Downstream of the MMU: consumes its single-outstanding physical memory request (request_enable/req_mode/req_addr/req_wdata/req_wstrb) and returns response_enable/resp_data.
- Converts each request into one AXI4-Lite master transaction toward the memory/peripheral interconnect.
- Exactly one transaction in flight; independent AW/W handshakes; registered one-cycle response pulse back to the MMU.

Parameters:
ADDR_WIDTH, 32, AXI address width; req_addr[ADDR_WIDTH-1:0] driven on awaddr/araddr.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
request_enable  in  1  one-cycle request strobe from MMU
req_mode  in  1  MEMREQ_READ=0, MEMREQ_WRITE=1
req_addr  in  32  physical byte address
req_wdata  in  32  write data
req_wstrb  in  4  byte strobes
response_enable  out  1  one-cycle completion pulse to MMU
resp_data  out  32  read data; 0 for writes
axi_awaddr  out  ADDR_WIDTH  write address
axi_awprot  out  3  constant 3'b000
axi_awvalid  out  1  AW valid
axi_awready  in  1  AW ready
axi_wdata  out  32  write data
axi_wstrb  out  4  write strobes
axi_wvalid  out  1  W valid
axi_wready  in  1  W ready
axi_bresp  in  2  write response code
axi_bvalid  in  1  B valid
axi_bready  out  1  B ready
axi_araddr  out  ADDR_WIDTH  read address
axi_arprot  out  3  constant 3'b000
axi_arvalid  out  1  AR valid
axi_arready  in  1  AR ready
axi_rdata  in  32  read data
axi_rresp  in  2  read response code
axi_rvalid  in  1  R valid
axi_rready  out  1  R ready

Behaviour:
- Reset (rstn low, async): state IDLE; all valid/ready outputs 0; response_enable 0; resp_data 0; addr/data/strb outputs 0; aw_done/w_done flags 0.
- Reset mid-transaction: transaction abandoned; no response pulse after release.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESPOND.
- IDLE: on request_enable, latch addr/wdata/wstrb.
  - mode 0: arvalid<=1, go RD_ADDR.
  - mode 1: awvalid<=1, wvalid<=1, clear aw_done/w_done, go WR_REQ.
- request_enable outside IDLE: ignored (MMU guarantees single outstanding).
- RD_ADDR: on arvalid&arready: arvalid<=0, rready<=1, go RD_DATA.
- RD_DATA: on rvalid&rready: rready<=0, resp_data<=rdata, response_enable<=1, go RESPOND.
- WR_REQ: AW and W complete independently.
  - awvalid&awready: drop awvalid, set aw_done.
  - wvalid&wready: drop wvalid, set w_done.
  - When both done (incl. same cycle, or one already done): bready<=1, go WR_RESP.
  - Valids never drop before their handshake; address/data stable while valid.
- WR_RESP: on bvalid&bready: bready<=0, resp_data<=0, response_enable<=1, go RESPOND.
- RESPOND: response_enable<=0, go IDLE. Pulse is exactly one cycle; resp_data holds until the next response.
- Best-case latency, request_enable to response_enable:
  - read with arready=1 and rvalid=1 the cycle after AR: 3 cycles.
  - write: 3 cycles.
- Earliest next request accepted: cycle after RESPOND.
- Without the optional feature, rresp/bresp are ignored and data is returned as-is.

Optional Feature:
- Macro: MEM_AXI_BRIDGE_RESP_ERR_EN.
- Defined: adds output resp_error (1 bit, reset 0). On the response_enable cycle it is set when the captured rresp[1] or bresp[1] is 1 (SLVERR/DECERR). On a read error resp_data is forced to 0. resp_error clears with response_enable.
- Undefined: port absent; response codes ignored.

Test Plan:
- Read, zero-wait slave: req_mode=0, req_addr=0x8000_0010, rdata=0xDEAD_BEEF -> araddr=0x8000_0010, one response_enable pulse, resp_data=0xDEAD_BEEF, 3 cycles.
- Write, AW ready 2 cycles before W: req_addr=0x1000_0004, wdata=0x1234_5678, wstrb=4'b0011 -> each valid held until its own handshake; bready only after both; response pulse after bvalid; resp_data=0.
- Write, AW and W ready same cycle; then back-to-back read issued the cycle after RESPOND -> both complete in order; the read is not dropped.
- Slow read slave (arready after 5 cycles, rvalid after 7 more) with spurious request_enable mid-transaction -> araddr/arvalid stable; extra request ignored; exactly one response.
- rstn asserted while in RD_DATA -> all outputs 0 immediately (async); no response pulse after release; next request served normally.
- With MEM_AXI_BRIDGE_RESP_ERR_EN: rresp=2'b10 -> resp_error=1 and resp_data=0 on the pulse cycle; bresp=2'b00 write -> resp_error=0.
